// File: rtl/llc_mem_responder.sv
// Memory-side endpoint of the LLC memory interface: line-wide storage with a fixed
// access latency, one request at a time, zeroed after every reset.
module llc_mem_responder #(
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LAT        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              llc_mem_req_valid,
  output logic              llc_mem_req_ready,
  input  logic              llc_mem_req_hwrite,
  input  logic [2:0]        llc_mem_req_hsize,
  input  logic [1:0]        llc_mem_req_hprot,
  input  logic [ADDR_W-1:0] llc_mem_req_addr,
  input  logic [LINE_W-1:0] llc_mem_req_line,
  output logic              llc_mem_rsp_valid,
  input  logic              llc_mem_rsp_ready,
  output logic [LINE_W-1:0] llc_mem_rsp_line,
  output logic              init_done
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = $clog2(LAT) + 1;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

  if (LAT < 1) begin : g_bad_lat
    $error("llc_mem_responder: LAT must be at least 1");
  end

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   clr_idx;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [CNT_W-1:0]        cnt;
  logic                    hwrite_q;
  logic [LINE_W-1:0]       line_q;
  logic [LINE_W-1:0]       mem [DEPTH];

  logic                    mem_we_c;
  logic [DEPTH_LOG2-1:0]   mem_waddr_c;
  logic [LINE_W-1:0]       mem_wdata_c;
  logic                    unused_c;

  // Size, protection and upper address bits carry no meaning for a whole-line store.
  assign unused_c = ^{llc_mem_req_hsize, llc_mem_req_hprot, llc_mem_req_addr};

  // Single write port: clear sweep in CLEAR, committed write at the end of WAIT.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = clr_idx;
    mem_wdata_c = '0;
    case (state)
      CLEAR: mem_we_c = 1'b1;
      WAIT: begin
        if (cnt == '0 && hwrite_q) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = idx;
          mem_wdata_c = line_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= CLEAR;
      clr_idx           <= '0;
      idx               <= '0;
      cnt               <= '0;
      hwrite_q          <= 1'b0;
      line_q            <= '0;
      llc_mem_req_ready <= 1'b0;
      llc_mem_rsp_valid <= 1'b0;
      llc_mem_rsp_line  <= '0;
      init_done         <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state             <= IDLE;
            llc_mem_req_ready <= 1'b1;
            init_done         <= 1'b1;
          end
        end
        IDLE: begin
          if (llc_mem_req_valid && llc_mem_req_ready) begin
            hwrite_q          <= llc_mem_req_hwrite;
            idx               <= llc_mem_req_addr[DEPTH_LOG2-1:0];
            line_q            <= llc_mem_req_line;
            cnt               <= CNT_W'(LAT - 1);
            state             <= WAIT;
            llc_mem_req_ready <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            if (hwrite_q) begin
              state             <= IDLE;
              llc_mem_req_ready <= 1'b1;
            end else begin
              llc_mem_rsp_line  <= mem[idx];
              llc_mem_rsp_valid <= 1'b1;
              state             <= RESP;
            end
          end
        end
        RESP: begin
          if (llc_mem_rsp_ready) begin
            llc_mem_rsp_valid <= 1'b0;
            llc_mem_req_ready <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_mem_responder.sv
// Directed bench for llc_mem_responder: clear timing, read latency, alias,
// backpressure, back-to-back write/read and reset in the middle of a transaction.
module tb_llc_mem_responder;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_hwrite;
  logic [2:0]        req_hsize;
  logic [1:0]        req_hprot;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_line;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [LINE_W-1:0] rsp_line;
  logic              init_done;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [LINE_W-1:0] L_BEEF = 128'h0000_0004_0000_0003_0000_0002_DEAD_BEEF;
  localparam logic [LINE_W-1:0] L_A5   = {16{8'hA5}};
  localparam logic [LINE_W-1:0] L_FF   = {LINE_W{1'b1}};

  llc_mem_responder #(
    .LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(8), .LAT(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .llc_mem_req_valid (req_valid),
    .llc_mem_req_ready (req_ready),
    .llc_mem_req_hwrite(req_hwrite),
    .llc_mem_req_hsize (req_hsize),
    .llc_mem_req_hprot (req_hprot),
    .llc_mem_req_addr  (req_addr),
    .llc_mem_req_line  (req_line),
    .llc_mem_rsp_valid (rsp_valid),
    .llc_mem_rsp_ready (rsp_ready),
    .llc_mem_rsp_line  (rsp_line),
    .init_done         (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts cycles spent in the post-reset clear, flagging init_done rising early.
  task automatic wait_init(output int n, output logic early);
    n = 0;
    early = 1'b0;
    while (req_ready !== 1'b1 && n < 400) begin
      if (init_done !== 1'b0) early = 1'b1;
      tick();
      n++;
    end
  endtask

  // Offers a request until accepted; n = cycles waited; returns in cycle T+1.
  task automatic do_req(input logic hw, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] d, output int n);
    req_valid  = 1'b1;
    req_hwrite = hw;
    req_addr   = a;
    req_line   = d;
    req_hsize  = 3'($urandom_range(0, 7));
    req_hprot  = 2'($urandom_range(0, 3));
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    req_line  = '0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic rsp_handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_ready_after"}, 128'(req_ready), 128'(1));
    check({tag, "_valid_after"}, 128'(rsp_valid), 128'(0));
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [LINE_W-1:0] exp);
    int n;
    do_req(1'b0, a, '0, n);
    wait_rsp(n);
    check({tag, "_lat"}, 128'(n), 128'(4));
    check({tag, "_line"}, rsp_line, exp);
    rsp_handshake(tag);
  endtask

  initial begin
    int   n;
    logic early;

    rst = 1'b1; req_valid = 1'b0; req_hwrite = 1'b0; req_hsize = '0;
    req_hprot = '0; req_addr = '0; req_line = '0; rsp_ready = 1'b0;

    // Reset and clear
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_line",  rsp_line, '0);
    check("rst_init_done", 128'(init_done), 128'(0));
    rst = 1'b0;
    wait_init(n, early);
    check("clear_cycles", 128'(n), 128'(256));
    check("clear_init_early", 128'(early), 128'(0));
    check("clear_init_done", 128'(init_done), 128'(1));
    repeat (5) tick();
    check("idle_ready_hold", 128'(req_ready), 128'(1));
    check("idle_init_hold", 128'(init_done), 128'(1));

    // Read after clear
    do_req(1'b0, 28'h5, '0, n);
    check("rd5_accept_wait", 128'(n), 128'(0));
    check("rd5_ready_low", 128'(req_ready), 128'(0));
    wait_rsp(n);
    check("rd5_lat", 128'(n), 128'(4));
    check("rd5_line", rsp_line, '0);
    check("rd5_ready_in_resp", 128'(req_ready), 128'(0));
    rsp_handshake("rd5");

    // Write, read back, alias, neighbour
    do_req(1'b1, 28'h12, L_BEEF, n);
    repeat (4) tick();
    check("wr12_no_rsp", 128'(rsp_valid), 128'(0));
    read_check("rd12", 28'h12, L_BEEF);
    read_check("rd112_alias", 28'h112, L_BEEF);
    read_check("rd13", 28'h13, '0);

    // Response backpressure
    do_req(1'b0, 28'h12, '0, n);
    wait_rsp(n);
    check("bp_lat", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 128'(rsp_valid), 128'(1));
      check("bp_line", rsp_line, L_BEEF);
      check("bp_req_ready", 128'(req_ready), 128'(0));
    end
    rsp_handshake("bp");

    // Back-to-back write then read of the same line
    do_req(1'b1, 28'h40, L_A5, n);
    do_req(1'b0, 28'h40, '0, n);
    check("b2b_accept_wait", 128'(n), 128'(4));
    wait_rsp(n);
    check("b2b_lat", 128'(n), 128'(4));
    check("b2b_line", rsp_line, L_A5);
    rsp_handshake("b2b");

    // Reset while a response is held
    do_req(1'b0, 28'h12, '0, n);
    wait_rsp(n);
    check("rr_line_before", rsp_line, L_BEEF);
    rst = 1'b1;
    #1;
    check("rr_valid_drop", 128'(rsp_valid), 128'(0));
    check("rr_line_clr", rsp_line, '0);
    check("rr_init_clr", 128'(init_done), 128'(0));
    tick(); tick();
    rst = 1'b0;
    wait_init(n, early);
    check("rr_clear_cycles", 128'(n), 128'(256));

    // Reset during the wait of a write
    do_req(1'b1, 28'h7, L_FF, n);
    tick();
    rst = 1'b1;
    #1;
    check("rw_valid", 128'(rsp_valid), 128'(0));
    check("rw_ready", 128'(req_ready), 128'(0));
    tick(); tick();
    rst = 1'b0;
    wait_init(n, early);
    check("rw_clear_cycles", 128'(n), 128'(256));
    check("rw_init_early", 128'(early), 128'(0));
    read_check("rw_rd7", 28'h7, '0);
    read_check("rw_rd40", 28'h40, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/llc_mem_responder.md
Name: llc_mem_responder

Overview:
- Memory-side endpoint of the LLC memory interface. Accepts LLC memory requests (line read or line write) and returns read lines on the memory response channel.
- Backed by an internal line-wide storage array with a fixed, parameterised access latency. Handles one request at a time.
- Used as the main-memory model under the LLC in block and cache-subsystem benches, and as a scratch line memory in small integrations.

Parameters:
- LINE_W, 128, line width in bits (4 words x 32 bits).
- ADDR_W, 28, line-address width in bits.
- DEPTH_LOG2, 8, log2 of the storage depth in lines (DEPTH = 256).
- LAT, 4, access latency in cycles. Minimum 1; LAT = 0 is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- llc_mem_req_valid  in  1  request valid.
- llc_mem_req_ready  out  1  request ready.
- llc_mem_req_hwrite  in  1  1 = line write, 0 = line read.
- llc_mem_req_hsize  in  3  access size. Ignored; every access is a whole line.
- llc_mem_req_hprot  in  2  protection bits. Ignored.
- llc_mem_req_addr  in  ADDR_W  line address.
- llc_mem_req_line  in  LINE_W  write data.
- llc_mem_rsp_valid  out  1  read response valid.
- llc_mem_rsp_ready  in  1  read response ready.
- llc_mem_rsp_line  out  LINE_W  read data.
- init_done  out  1  high once the post-reset clear has finished.

Behaviour:
- Reset is asynchronous and active-high: clk with rst, rst asserted high. While rst is high:
  - state = CLEAR, clr_idx = 0, cnt = 0;
  - llc_mem_req_ready = 0, llc_mem_rsp_valid = 0, llc_mem_rsp_line = 0, init_done = 0.
- States: CLEAR, IDLE, WAIT, RESP.
  - llc_mem_req_ready = 1 iff state == IDLE.
  - llc_mem_rsp_valid = 1 iff state == RESP.
- CLEAR:
  - Each cycle writes mem[clr_idx] = 0 and increments clr_idx (DEPTH_LOG2 bits).
  - On the cycle clr_idx == DEPTH-1, go to IDLE and set init_done = 1. clr_idx wraps to 0.
  - CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - init_done stays 1 until the next reset.
- IDLE:
  - A handshake (valid & ready) in cycle T captures hwrite, idx = addr[DEPTH_LOG2-1:0] and line, loads cnt = LAT-1, and goes to WAIT.
  - Upper address bits are ignored, so addresses alias modulo DEPTH.
- WAIT:
  - cnt decrements each cycle.
  - In the cycle cnt == 0, for a write: mem[idx] = captured line, then go to IDLE.
  - In the cycle cnt == 0, for a read: register llc_mem_rsp_line = mem[idx], then go to RESP.
  - WAIT occupies cycles T+1 .. T+LAT.
  - Read: llc_mem_rsp_valid first goes high in cycle T+LAT+1.
  - Write: the next request can be accepted in cycle T+LAT+1, and a read accepted then returns the new data.
  - Writes produce no response.
- RESP:
  - llc_mem_rsp_valid and llc_mem_rsp_line are held stable until llc_mem_rsp_ready.
  - A handshake in cycle R goes to IDLE, with llc_mem_req_ready = 1 in cycle R+1.
  - llc_mem_rsp_line keeps its last value after the handshake.
- cnt width is $clog2(LAT)+1. For LAT = 1, WAIT lasts a single cycle.
- Inputs are don't-care outside IDLE. No request is accepted in CLEAR, WAIT or RESP.
- Reset mid-operation (any state):
  - the in-flight request is discarded; a pending write is not committed and any held response is dropped;
  - the block re-enters CLEAR and the whole array is re-zeroed.
- Storage uses one port, read and written only from the FSM. There are no simultaneous-access hazards.

Test Plan:
- Reset: rst high 3 cycles, then low → req_ready = 0 and init_done = 0 for exactly 256 cycles; both go to 1 in the 257th cycle and stay there.
- Read after clear: read of addr 0x5 handshaken in cycle T → rsp_valid in cycle T+5 with line = 0; req_ready = 0 from T+1 until after the response handshake.
- Write/read/alias:
  - write addr 0x12, line 0x0000_0004_0000_0003_0000_0002_DEAD_BEEF;
  - read 0x12 → that line;
  - read 0x112 → same line (alias);
  - read 0x13 → 0.
- Backpressure: hold rsp_ready = 0 for 10 cycles during a read response → rsp_valid stays 1, line stays stable, req_ready stays 0; raise rsp_ready in cycle R → req_ready = 1 in R+1.
- Back-to-back: write 0x40 = 0xA5A5…A5 accepted in cycle T; read 0x40 offered continuously → accepted in cycle T+5, returns 0xA5A5…A5 in cycle T+10.
- Reset mid-WAIT: assert rst during WAIT of a write to 0x7 (0xFF…FF) → rsp_valid = 0 immediately; after the 256-cycle CLEAR, a read of 0x7 returns 0.
